// File: rtl/mult_pkg.sv
// Shared definitions for the sequential multiplier family.
// Contents:
//   state_e - control states IDLE / RUN / DONE
//   cnt_w   - counter width needed to count WIDTH iterations
//   prod_w  - product width for a WIDTH x WIDTH multiply
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int cnt_w(input int width);
    return $clog2(width) + 1;
  endfunction

  function automatic int prod_w(input int width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/mult_add_row.sv
// WIDTH-bit adder with carry-out: one partial-product row of a
// multi-cycle multiplier.
// Ports:
//   a_i    - first addend (upper half of the running accumulator)
//   b_i    - second addend (multiplicand or zero)
//   sum_o  - WIDTH-bit sum
//   cout_o - carry out of the top bit
module mult_add_row #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i};

endmodule

// File: rtl/seq_mult.sv
// Sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, one partial
// product per clock, with start/busy/done handshake.
// Build option: define SEQ_MULT_SIGNED_EN to honour signed_mode
// (two's-complement operands and product). Without it every operation is
// unsigned and signed_mode is ignored.
// Ports:
//   clk         - clock, rising edge
//   rst_n       - synchronous active-low reset
//   start       - operation request, taken in IDLE or DONE
//   a, b        - multiplicand / multiplier, latched on accepted start
//   signed_mode - 1 = two's-complement operation (latched on start)
//   busy        - operation in progress
//   done        - one-cycle pulse, product valid
//   product     - result, held until the next done
module seq_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = cnt_w(WIDTH);
  localparam int PW = prod_w(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    product_q, product_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0] row_b;
  logic [WIDTH-1:0] row_sum;
  logic             row_cout;
  logic [PW-1:0]    acc_shift;
  logic [PW-1:0]    result;

`ifdef SEQ_MULT_SIGNED_EN
  logic neg_q, neg_d;
`else
  logic signed_mode_unused;
  assign signed_mode_unused = signed_mode;
`endif

  assign row_b = mplier_q[0] ? mcand_q : '0;

  mult_add_row #(.WIDTH(WIDTH)) u_row (
    .a_i   (acc_q[PW-1:WIDTH]),
    .b_i   (row_b),
    .sum_o (row_sum),
    .cout_o(row_cout)
  );

  // Add result lands in the upper half, then {carry, acc} shifts right by one.
  assign acc_shift = {row_cout, row_sum, acc_q[WIDTH-1:1]};

`ifdef SEQ_MULT_SIGNED_EN
  assign result = neg_q ? (~acc_shift + PW'(1)) : acc_shift;
`else
  assign result = acc_shift;
`endif

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    product_d = product_q;
    cnt_d     = cnt_q;
`ifdef SEQ_MULT_SIGNED_EN
    neg_d     = neg_q;
`endif
    case (state_q)
      RUN: begin
        acc_d    = acc_shift;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          product_d = result;
          state_d   = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        if (start) begin
          state_d  = RUN;
          acc_d    = '0;
          cnt_d    = '0;
          mcand_d  = a;
          mplier_d = b;
`ifdef SEQ_MULT_SIGNED_EN
          neg_d    = 1'b0;
          // Operate on magnitudes; the most negative value maps to 2^(WIDTH-1)
          // which still fits as an unsigned WIDTH-bit magnitude.
          if (signed_mode) begin
            mcand_d = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
            mplier_d = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
            neg_d   = a[WIDTH-1] ^ b[WIDTH-1];
          end
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      product_q <= '0;
      cnt_q     <= '0;
`ifdef SEQ_MULT_SIGNED_EN
      neg_q     <= 1'b0;
`endif
    end else begin
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      cnt_q     <= cnt_d;
`ifdef SEQ_MULT_SIGNED_EN
      neg_q     <= neg_d;
`endif
    end
  end

  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule
